// File: rtl/gshare_bht_if.sv
// Fetch-side lookup and execute-side update/repair signals of the gshare branch history table.
// The predictor is the slave; the core pipeline (or a bench) is the master.
interface gshare_bht_if #(
  parameter int INDEX_WIDTH = 6,
  parameter int GHR_WIDTH   = 4
);
  logic                   i_pred_valid;
  logic [INDEX_WIDTH-1:0] i_set_index;
  logic                   o_pred_taken;
  logic [GHR_WIDTH-1:0]   o_pred_ghr;
  logic                   o_ready;
  logic                   i_bht_update;
  logic                   i_branch_taken;
  logic [INDEX_WIDTH-1:0] i_set_index_exec;
  logic [GHR_WIDTH-1:0]   i_ghr_exec;
  logic                   i_mispredict;

  modport master (
    output i_pred_valid, i_set_index,
    output i_bht_update, i_branch_taken, i_set_index_exec, i_ghr_exec, i_mispredict,
    input  o_pred_taken, o_pred_ghr, o_ready
  );

  modport slave (
    input  i_pred_valid, i_set_index,
    input  i_bht_update, i_branch_taken, i_set_index_exec, i_ghr_exec, i_mispredict,
    output o_pred_taken, o_pred_ghr, o_ready
  );
endinterface

// File: rtl/gshare_bht.sv
// Gshare/bimodal predictor: N-bit saturating counters plus speculative GHR with execute-side repair.
// Prediction is combinational (0 cycles); updates land next cycle; no backpressure, o_ready gates use after the init sweep.
module gshare_bht #(
  parameter int SET_COUNT     = 64,
  parameter int INDEX_WIDTH   = 6,
  parameter int SATUR_COUNT_W = 2,
  parameter int GHR_WIDTH     = 4,
  parameter bit GSHARE_EN     = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_arst,
  gshare_bht_if.slave bus
);
  localparam int W  = SATUR_COUNT_W;
  localparam int IW = INDEX_WIDTH;
  localparam int GW = GHR_WIDTH;
  localparam logic [W-1:0]  WEAK_TAKEN = W'(1 << (W - 1));
  localparam logic [IW-1:0] LAST_IDX   = IW'(SET_COUNT - 1);

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  state_t          state_q;
  logic [IW-1:0]   init_ptr_q;
  logic            ready_q;
  logic [GW-1:0]   ghr_q;
  logic [GW-1:0]   ghr_d;
  logic [W-1:0]    mem_q [SET_COUNT];

  logic [IW-1:0]   ghr_ext;
  logic [IW-1:0]   exec_ghr_ext;
  logic [IW-1:0]   fetch_idx;
  logic [IW-1:0]   upd_idx;
  logic            pred_taken;
  logic [W:0]      cnt_ext;
  logic [W:0]      cnt_nxt;
  logic            cnt_wr;
  logic [GW-1:0]   repair_hist;
  logic [GW-1:0]   spec_hist;

  always_comb begin
    ghr_ext                = '0;
    exec_ghr_ext           = '0;
    ghr_ext[GW-1:0]        = ghr_q;
    exec_ghr_ext[GW-1:0]   = bus.i_ghr_exec;
  end

  if (GSHARE_EN) begin : g_gshare
    assign fetch_idx = bus.i_set_index ^ ghr_ext;
    assign upd_idx   = bus.i_set_index_exec ^ exec_ghr_ext;
  end else begin : g_bimodal
    assign fetch_idx = bus.i_set_index;
    assign upd_idx   = bus.i_set_index_exec;
  end

  // Read is taken from the registered table, so a same-cycle update to this entry is not seen.
  assign pred_taken       = ready_q & mem_q[fetch_idx][W-1];
  assign bus.o_pred_taken = pred_taken;
  assign bus.o_pred_ghr   = ghr_q;
  assign bus.o_ready      = ready_q;

  // One extra bit catches both overflow at max and underflow at zero; either suppresses the write.
  always_comb begin
    cnt_ext = {1'b0, mem_q[upd_idx]};
    cnt_nxt = bus.i_branch_taken ? cnt_ext + (W+1)'(1) : cnt_ext - (W+1)'(1);
    cnt_wr  = ready_q & bus.i_bht_update & ~cnt_nxt[W];
  end

  if (GW == 1) begin : g_hist1
    assign repair_hist = bus.i_branch_taken;
    assign spec_hist   = pred_taken;
  end else begin : g_histn
    assign repair_hist = {bus.i_ghr_exec[GW-2:0], bus.i_branch_taken};
    assign spec_hist   = {ghr_q[GW-2:0], pred_taken};
  end

  always_comb begin
    ghr_d = ghr_q;
    if (ready_q) begin
      if (bus.i_bht_update && bus.i_mispredict) begin
        ghr_d = repair_hist;
      end else if (bus.i_pred_valid) begin
        ghr_d = spec_hist;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) begin
      state_q    <= ST_INIT;
      init_ptr_q <= '0;
      ready_q    <= 1'b0;
    end else if (state_q == ST_INIT) begin
      init_ptr_q <= init_ptr_q + 1'b1;
      if (init_ptr_q == LAST_IDX) begin
        state_q <= ST_READY;
        ready_q <= 1'b1;
      end
    end
  end

  // Table has no reset of its own; the sweep rewrites every entry after each reset.
  always_ff @(posedge i_clk) begin
    if (!i_arst) begin
      if (state_q == ST_INIT) begin
        mem_q[init_ptr_q] <= WEAK_TAKEN;
      end else if (cnt_wr) begin
        mem_q[upd_idx] <= cnt_nxt[W-1:0];
      end
    end
  end
endmodule

// File: tb/tb_gshare_bht.sv
// Randomised and directed checks of gshare_bht against an integer-array predictor model.
module tb_gshare_bht;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  gshare_bht_if #(.INDEX_WIDTH(6), .GHR_WIDTH(4)) bus ();

  gshare_bht #(
    .SET_COUNT(64), .INDEX_WIDTH(6), .SATUR_COUNT_W(2), .GHR_WIDTH(4), .GSHARE_EN(1'b1)
  ) dut (
    .i_clk (clk),
    .i_arst(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int mem_m [64];
  int ghr_m = 0;
  int icnt = 0;
  bit rdy_m = 1'b0;
  bit model_live = 1'b0;

  function automatic int fidx(int idx, int h);
    return (idx ^ h) & 63;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: 0..3 counters in an int array, history as a 4-bit integer.
  always @(posedge clk) begin
    int pred;
    int e;
    int c;
    if (rst) begin
      rdy_m = 1'b0;
      icnt = 0;
      ghr_m = 0;
      model_live = 1'b1;
    end else if (model_live) begin
      if (!rdy_m) begin
        mem_m[icnt] = 2;
        icnt++;
        if (icnt == 64) rdy_m = 1'b1;
      end else begin
        pred = (mem_m[fidx(int'(bus.i_set_index), ghr_m)] >= 2) ? 1 : 0;
        if (bus.i_bht_update) begin
          e = fidx(int'(bus.i_set_index_exec), int'(bus.i_ghr_exec));
          c = mem_m[e];
          if (bus.i_branch_taken) c = (c < 3) ? c + 1 : 3;
          else                    c = (c > 0) ? c - 1 : 0;
          mem_m[e] = c;
        end
        if (bus.i_bht_update && bus.i_mispredict)
          ghr_m = ((int'(bus.i_ghr_exec) << 1) | int'(bus.i_branch_taken)) & 15;
        else if (bus.i_pred_valid)
          ghr_m = ((ghr_m << 1) | pred) & 15;
      end
    end
  end

  always @(negedge clk) begin
    int exp_pred;
    if (model_live) begin
      exp_pred = rdy_m ? ((mem_m[fidx(int'(bus.i_set_index), ghr_m)] >= 2) ? 1 : 0) : 0;
      check("cyc_ready", int'(bus.o_ready), int'(rdy_m));
      check("cyc_pred_taken", int'(bus.o_pred_taken), exp_pred);
      check("cyc_pred_ghr", int'(bus.o_pred_ghr), ghr_m);
    end
  end

  task automatic set_in(int pv, int idx, int upd, int tk, int eidx, int gex, int mis);
    bus.i_pred_valid     = 1'(pv);
    bus.i_set_index      = 6'(idx);
    bus.i_bht_update     = 1'(upd);
    bus.i_branch_taken   = 1'(tk);
    bus.i_set_index_exec = 6'(eidx);
    bus.i_ghr_exec       = 4'(gex);
    bus.i_mispredict     = 1'(mis);
  endtask

  task automatic cyc(int pv, int idx, int upd, int tk, int eidx, int gex, int mis);
    set_in(pv, idx, upd, tk, eidx, gex, mis);
    @(posedge clk);
    #1;
    set_in(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic peek(string name, int idx, int exp);
    set_in(0, idx, 0, 0, 0, 0, 0);
    #1;
    check(name, int'(bus.o_pred_taken), exp);
  endtask

  task automatic rand_in();
    int idx;
    idx = $urandom_range(0, 63);
    set_in($urandom_range(0, 1), idx, $urandom_range(0, 1), $urandom_range(0, 1),
           ($urandom_range(0, 3) == 0) ? idx : $urandom_range(0, 63),
           $urandom_range(0, 15), ($urandom_range(0, 3) == 0) ? 1 : 0);
  endtask

  int exp_sat_tk [3] = '{3, 3, 3};
  int exp_sat_nt [4] = '{2, 1, 0, 0};

  initial begin
    set_in(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", int'(bus.o_ready), 0);
    check("reset_ghr", int'(bus.o_pred_ghr), 0);
    rst = 1'b0;

    // Sweep cycles 0..63: not ready, no prediction, inputs ignored.
    for (int i = 0; i < 64; i++) begin
      rand_in();
      #1;
      check("init_ready_low", int'(bus.o_ready), 0);
      check("init_pred_zero", int'(bus.o_pred_taken), 0);
      @(posedge clk);
      #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("init_ready_at_64", int'(bus.o_ready), 1);
    check("init_ghr_held", int'(bus.o_pred_ghr), 0);
    for (int i = 0; i < 64; i++) peek("init_entry_weak_taken", i, 1);
    check("model_init_entry", mem_m[37], 2);

    // Saturation on entry 5 with history 0.
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 1, 1, 5, 0, 0);
      check("sat_up_model", mem_m[5], exp_sat_tk[i]);
      peek("sat_up_pred", 5, 1);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 1, 0, 5, 0, 0);
      check("sat_dn_model", mem_m[5], exp_sat_nt[i]);
      peek("sat_dn_pred", 5, (exp_sat_nt[i] >= 2) ? 1 : 0);
    end

    // Gshare separation: PC 6 maps to entry 5 under history 0011 and to entry 6 under 0000.
    cyc(0, 0, 1, 1, 'h20, 1, 1);
    check("sep_ghr_0011", int'(bus.o_pred_ghr), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 6, 3, 0);
    peek("sep_entry5_taken", 6, 1);
    cyc(0, 0, 1, 0, 'h30, 0, 1);
    check("sep_ghr_0000", int'(bus.o_pred_ghr), 0);
    peek("sep_entry6_untouched", 6, 1);
    cyc(0, 0, 1, 0, 6, 0, 0);
    cyc(0, 0, 1, 0, 6, 0, 0);
    peek("sep_entry6_trained", 6, 0);
    cyc(0, 0, 1, 1, 'h20, 1, 1);
    peek("sep_entry5_kept", 6, 1);
    check("sep_model_e5", mem_m[5], 3);
    check("sep_model_e6", mem_m[6], 0);

    // Repair overrides a same-cycle speculative shift.
    cyc(0, 0, 1, 0, 'h38, 0, 1);
    for (int i = 0; i < 3; i++) cyc(1, 'h10, 0, 0, 0, 0, 0);
    check("repair_spec_0111", int'(bus.o_pred_ghr), 7);
    cyc(1, 'h10, 1, 0, 'h28, 1, 1);
    check("repair_ghr_0010", int'(bus.o_pred_ghr), 2);

    // Collision: the fetch sees the pre-update counter of entry 9.
    cyc(0, 0, 1, 0, 9, 0, 1);
    check("coll_ghr_zero", int'(bus.o_pred_ghr), 0);
    set_in(1, 9, 1, 1, 9, 0, 0);
    #1;
    check("coll_pred_old", int'(bus.o_pred_taken), 0);
    @(posedge clk);
    #1;
    peek("coll_pred_new", 9, 1);
    check("coll_model_e9", mem_m[9], 2);

    for (int i = 0; i < 1500; i++) begin
      rand_in();
      @(posedge clk);
      #1;
    end

    // Mid-run reset with traffic still present.
    rand_in();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midrst_ready_drop", int'(bus.o_ready), 0);
    check("midrst_ghr_zero", int'(bus.o_pred_ghr), 0);
    for (int i = 0; i < 64; i++) begin
      rand_in();
      bus.i_bht_update = 1'b1;
      bus.i_pred_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    set_in(0, 0, 0, 0, 0, 0, 0);
    check("midrst_ready_back", int'(bus.o_ready), 1);
    check("midrst_ghr_held", int'(bus.o_pred_ghr), 0);
    for (int i = 0; i < 64; i++) peek("midrst_entry_weak_taken", i, 1);

    @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
